enemy_laser: RTL and testbench
==============================

# enemy_laser

Single enemy projectile for the space-invaders core. It is the producer side of the player ship's `hit_i`: it accepts a fire request from the invader formation and falls one step per frame. It tests overlap against the player's `pos_left_o`/`pos_right_o` band and emits a one-cycle `hit_o` pulse. Instantiate N copies for N concurrent enemy shots and OR their `hit_o` outputs into the ship's `hit_i`.

## Interface
- `color_p`, {4'hF,4'hF,4'hF}: laser colour, {R,G,B}
- `step_p`, 10'd8: pixels fallen per frame
- `laser_w_p`, 10'd3: laser width in pixels
- `laser_h_p`, 10'd12: laser height in pixels
- `player_top_p`, 10'd440: top row of the player ship
- `player_bot_p`, 10'd455: bottom row of the player ship
- `bottom_border_p`, 10'd479: last visible row
- `cooldown_p`, 6'd8: frames spent in cooldown before re-arming

Ports:
- `clk_i` in 1: clock
- `reset_i` in 1: synchronous, active-high reset
- `frame_i` in 1: one-cycle frame tick
- `fire_i` in 1: fire request from the formation
- `fire_x_i` in 10: spawn column (left edge)
- `fire_y_i` in 10: spawn row (top edge)
- `freeze_i` in 1: game paused (player in a shot state); halts all motion and counting
- `player_left_i` in 10: player left edge
- `player_right_i` in 10: player right edge
- `player_alive_i` in 1: player alive; gates collision
- `hit_o` out 1: one-cycle hit pulse
- `ready_o` out 1: idle and accepting `fire_i`
- `active_o` out 1: laser is visible (falling)
- `laser_x_o` out 10: laser left edge
- `laser_y_o` out 10: laser top edge
- `laser_red_o`, `laser_green_o`, `laser_blue_o` out 4 each: colour for display
- `state_o` out 4: present state, for debug

## Operation
- One-hot FSM states: IDLE=0001, FALLING=0010, IMPACT=0100, COOLDOWN=1000. Any other encoding goes to IDLE on the next cycle.
- IDLE
  - `ready_o`=1.
  - `fire_i`=1 loads x←`fire_x_i` and y←`fire_y_i`, then goes to FALLING. `freeze_i` does not block loading.
- FALLING
  - `active_o`=1. Only `frame_i`&~`freeze_i` cycles act. The test uses the pre-move position, and the first matching rule wins:
  - hit: `player_alive_i` & (y+`laser_h_p` ≥ `player_top_p`) & (y ≤ `player_bot_p`) & (x < `player_right_i`) & (x+`laser_w_p` > `player_left_i`) → IMPACT.
  - miss: y+`step_p`+`laser_h_p` > `bottom_border_p` → COOLDOWN.
  - otherwise: y ← y+`step_p`.
- IMPACT
  - `hit_o`=1 for exactly this one cycle, then COOLDOWN unconditionally, even while frozen.
- COOLDOWN
  - The counter loads `cooldown_p` on entry and decrements on `frame_i`&~`freeze_i`.
  - On the tick where the counter equals 0 → IDLE.
- `fire_i` outside IDLE is ignored; no queueing.
- Arithmetic: every comparison is done 11 bits wide (zero-extended) so the bottom-edge sums never wrap.
- Outputs `laser_x_o`/`laser_y_o` hold their last values outside FALLING. The colour outputs are constant from `color_p`.

## Timing
- Reset values: state=IDLE, x=0, y=0, cooldown=0, `hit_o`=0, `ready_o`=1, `active_o`=0, `state_o`=4'b0001.
- `reset_i` takes priority over every other input in every state, including mid-flight and in IMPACT. A pending hit pulse is dropped.
- Fire-to-FALLING latency is 1 cycle; the first move happens on the next qualifying frame.
- `hit_o` is registered: it rises on the clock edge after the qualifying frame tick and lasts 1 cycle. The player FSM samples it combinationally on that cycle.
- Cooldown length is `cooldown_p`+1 qualifying frames after entry, then `ready_o` rises.

## Structure
- Shared `invaders_pkg`:
  - laser state enum
  - screen constants (`bottom_border`, `player_top`, `player_bot`)
  - left/right border constants, moved there from the player
- Reuse the existing `counter` sub-module:
  - one instance, width 10, for y (load_i=fire, up_i=move, step_p=`step_p`)
  - one instance, width 6, for cooldown (load on entry, down on tick)
- The FSM and collision compare stay in `enemy_laser`.

## Test plan
- Reset: assert `reset_i` for 2 cycles → `state_o`=0001, `ready_o`=1, `hit_o`=0, `laser_y_o`=0.
- Direct hit: fire x=260, y=100 with player 249..289 alive.
  - y steps 100, 108, …, 428 over 41 frames.
  - On the 42nd frame `hit_o` pulses for exactly 1 cycle.
  - COOLDOWN follows, and `ready_o` rises after 9 frames.
- Miss: fire x=100, y=100 with player at 249..289.
  - No `hit_o`; COOLDOWN is entered on the frame where y=460.
  - `laser_y_o` stays at 460.
- Freeze: mid-flight at y=200, hold `freeze_i` for 10 frames → y stays at 200 and the state stays FALLING. On release y=208 after the next frame.
- Ignored and priority inputs:
  - `fire_i` with x=500 while FALLING → x unchanged.
  - `fire_i`+`reset_i` in the same cycle → IDLE, y=0.
- Dead player: `player_alive_i`=0 with full overlap at y=440 → no `hit_o`; the laser continues to a miss.

Source files
------------

// File: rtl/invaders_pkg.sv
`default_nettype none
// ============================================================================
// Module      : invaders_pkg
// Description : Shared types and screen geometry for the space-invaders core.
// Revision    : 1.0 - enemy laser state type and screen constants
// ============================================================================
package invaders_pkg;

    // One-hot enemy laser states; the codes are also exported on state_o.
    typedef enum logic [3:0] {
        LASER_IDLE     = 4'b0001,
        LASER_FALLING  = 4'b0010,
        LASER_IMPACT   = 4'b0100,
        LASER_COOLDOWN = 4'b1000
    } laser_state_t;

    // Screen geometry shared by the player ship and the enemy shots.
    localparam logic [9:0] c_bottom_border = 10'd479;
    localparam logic [9:0] c_player_top    = 10'd440;
    localparam logic [9:0] c_player_bot    = 10'd455;
    localparam logic [9:0] c_left_border   = 10'd0;
    localparam logic [9:0] c_right_border  = 10'd639;

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module      : counter
// Description : Loadable up/down counter with a fixed step size.
// Revision    : 1.0 - load has priority over up, up over down
// ============================================================================
module counter #(
    parameter int unsigned width_p = 10,
    parameter int unsigned step_p  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] c_step = width_p'(step_p);

    logic [width_p-1:0] r_count;

    // Load wins over counting so a fresh value is never lost to a step.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (up_i) begin
            r_count <= r_count + c_step;
        end else if (down_i) begin
            r_count <= r_count - c_step;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/enemy_laser.sv
`default_nettype none
// ============================================================================
// Module      : enemy_laser
// Description : Single falling enemy projectile with player collision test.
//               Several instances may be OR-ed onto the ship's hit input.
// Revision    : 1.0 - FSM, collision compare, y and cooldown counters
// ============================================================================
module enemy_laser
    import invaders_pkg::*;
#(
    parameter logic [11:0] color_p         = {4'hF, 4'hF, 4'hF},
    parameter logic [9:0]  step_p          = 10'd8,
    parameter logic [9:0]  laser_w_p       = 10'd3,
    parameter logic [9:0]  laser_h_p       = 10'd12,
    parameter logic [9:0]  player_top_p    = c_player_top,
    parameter logic [9:0]  player_bot_p    = c_player_bot,
    parameter logic [9:0]  bottom_border_p = c_bottom_border,
    parameter logic [5:0]  cooldown_p      = 6'd8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_i,
    input  logic       fire_i,
    input  logic [9:0] fire_x_i,
    input  logic [9:0] fire_y_i,
    input  logic       freeze_i,
    input  logic [9:0] player_left_i,
    input  logic [9:0] player_right_i,
    input  logic       player_alive_i,
    output logic       hit_o,
    output logic       ready_o,
    output logic       active_o,
    output logic [9:0] laser_x_o,
    output logic [9:0] laser_y_o,
    output logic [3:0] laser_red_o,
    output logic [3:0] laser_green_o,
    output logic [3:0] laser_blue_o,
    output logic [3:0] state_o
);

    laser_state_t r_state;
    logic [9:0]   r_x;
    logic         r_hit;
    logic         r_ready;
    logic         r_active;

    logic [9:0]   w_y;
    logic [5:0]   w_cd;
    logic         w_tick;
    logic         w_fire_load;
    logic         w_hit_cond;
    logic         w_miss_cond;
    logic         w_move;
    logic         w_cd_load;
    logic         w_cd_down;

    // All geometry is compared 11 bits wide so the bottom-edge sums cannot wrap.
    logic [10:0]  w_x_ext;
    logic [10:0]  w_y_ext;

    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, w_y};

    assign w_tick      = frame_i & ~freeze_i;
    assign w_fire_load = (r_state == LASER_IDLE) & fire_i;

    // Collision and miss tests use the position before this frame's move.
    assign w_hit_cond  = player_alive_i
                       & ((w_y_ext + {1'b0, laser_h_p}) >= {1'b0, player_top_p})
                       & (w_y_ext <= {1'b0, player_bot_p})
                       & (w_x_ext < {1'b0, player_right_i})
                       & ((w_x_ext + {1'b0, laser_w_p}) > {1'b0, player_left_i});
    assign w_miss_cond = (w_y_ext + {1'b0, step_p} + {1'b0, laser_h_p})
                       > {1'b0, bottom_border_p};

    assign w_move    = (r_state == LASER_FALLING) & w_tick & ~w_hit_cond & ~w_miss_cond;
    assign w_cd_load = (r_state == LASER_IMPACT)
                     | ((r_state == LASER_FALLING) & w_tick & ~w_hit_cond & w_miss_cond);
    assign w_cd_down = (r_state == LASER_COOLDOWN) & w_tick & (w_cd != 6'd0);

    counter #(
        .width_p (10),
        .step_p  (int'(step_p))
    ) u_y_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (w_fire_load),
        .load_val_i (fire_y_i),
        .up_i       (w_move),
        .down_i     (1'b0),
        .count_o    (w_y)
    );

    counter #(
        .width_p (6),
        .step_p  (1)
    ) u_cd_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (w_cd_load),
        .load_val_i (cooldown_p),
        .up_i       (1'b0),
        .down_i     (w_cd_down),
        .count_o    (w_cd)
    );

    // Laser lifecycle with registered status outputs; reset drops any pending hit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= LASER_IDLE;
            r_x      <= 10'd0;
            r_hit    <= 1'b0;
            r_ready  <= 1'b1;
            r_active <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                LASER_IDLE: begin
                    if (fire_i) begin
                        r_x      <= fire_x_i;
                        r_state  <= LASER_FALLING;
                        r_ready  <= 1'b0;
                        r_active <= 1'b1;
                    end
                end
                LASER_FALLING: begin
                    if (w_tick) begin
                        if (w_hit_cond) begin
                            r_state  <= LASER_IMPACT;
                            r_hit    <= 1'b1;
                            r_active <= 1'b0;
                        end else if (w_miss_cond) begin
                            r_state  <= LASER_COOLDOWN;
                            r_active <= 1'b0;
                        end
                    end
                end
                LASER_IMPACT: begin
                    r_state <= LASER_COOLDOWN;
                end
                LASER_COOLDOWN: begin
                    if (w_tick && (w_cd == 6'd0)) begin
                        r_state <= LASER_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= LASER_IDLE;
                    r_ready  <= 1'b1;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign hit_o         = r_hit;
    assign ready_o       = r_ready;
    assign active_o      = r_active;
    assign laser_x_o     = r_x;
    assign laser_y_o     = w_y;
    assign laser_red_o   = color_p[11:8];
    assign laser_green_o = color_p[7:4];
    assign laser_blue_o  = color_p[3:0];
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_enemy_laser.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_laser
// Description : Self-checking bench for enemy_laser; each shot's outcome is
//               predicted from the falling/collision rules before it is flown.
// Revision    : 1.0 - directed scenarios plus randomized shots
// ============================================================================
module tb_enemy_laser;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       frame_i = 1'b0;
    logic       fire_i = 1'b0;
    logic [9:0] fire_x_i = '0;
    logic [9:0] fire_y_i = '0;
    logic       freeze_i = 1'b0;
    logic [9:0] player_left_i = '0;
    logic [9:0] player_right_i = '0;
    logic       player_alive_i = 1'b0;
    logic       hit_o, ready_o, active_o;
    logic [9:0] laser_x_o, laser_y_o;
    logic [3:0] laser_red_o, laser_green_o, laser_blue_o, state_o;

    int n_checks = 0;
    int n_fail   = 0;

    enemy_laser dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .frame_i        (frame_i),
        .fire_i         (fire_i),
        .fire_x_i       (fire_x_i),
        .fire_y_i       (fire_y_i),
        .freeze_i       (freeze_i),
        .player_left_i  (player_left_i),
        .player_right_i (player_right_i),
        .player_alive_i (player_alive_i),
        .hit_o          (hit_o),
        .ready_o        (ready_o),
        .active_o       (active_o),
        .laser_x_o      (laser_x_o),
        .laser_y_o      (laser_y_o),
        .laser_red_o    (laser_red_o),
        .laser_green_o  (laser_green_o),
        .laser_blue_o   (laser_blue_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Fly one shot from fire to re-arm, with random frame/freeze/fire noise.
    task automatic run_shot(input int x0, input int y0, input int pl, input int pr,
                            input bit alive, input int frame_pct, input int freeze_pct,
                            input bit noisy_fire);
        int  k, q, c, yk, budget;
        bit  is_hit, f, z;
        player_left_i  = 10'(pl);
        player_right_i = 10'(pr);
        player_alive_i = alive;
        check("ready_before_fire", ready_o, 1);
        fire_i = 1'b1; fire_x_i = 10'(x0); fire_y_i = 10'(y0);
        frame_i = 1'b0; freeze_i = 1'b0;
        cyc();
        fire_i = 1'b0;
        check("active_after_fire", active_o, 1);
        check("ready_after_fire", ready_o, 0);
        check("x_loaded", laser_x_o, x0);
        check("y_loaded", laser_y_o, y0);
        check("state_falling", state_o, 4'b0010);

        // Predict: the qualifying frame index k (0-based) at which the laser ends.
        k = 0;
        forever begin
            yk = y0 + 8 * k;
            if (alive && (yk + 12 >= 440) && (yk <= 455) && (x0 < pr) && (x0 + 3 > pl)) begin
                is_hit = 1'b1;
                break;
            end
            if (yk + 20 > 479) begin
                is_hit = 1'b0;
                break;
            end
            k++;
        end

        q = 0;
        budget = 0;
        while (q <= k && budget < 4000) begin
            f = ($urandom % 100) < frame_pct;
            z = ($urandom % 100) < freeze_pct;
            frame_i  = f;
            freeze_i = z;
            fire_i   = noisy_fire && (($urandom % 4) == 0);
            fire_x_i = 10'($urandom % 1024);
            fire_y_i = 10'($urandom % 1024);
            cyc();
            budget++;
            if (f && !z) q++;
            check("x_held", laser_x_o, x0);
            if (q <= k) begin
                check("y_fall", laser_y_o, y0 + 8 * q);
                check("state_fall", state_o, 4'b0010);
                check("hit_quiet", hit_o, 0);
            end else begin
                check("y_final", laser_y_o, y0 + 8 * k);
                check("hit_pulse", hit_o, is_hit);
                check("state_end", state_o, is_hit ? 4'b0100 : 4'b1000);
            end
        end
        check("flight_done", q > k, 1);
        frame_i = 1'b0; freeze_i = 1'b0; fire_i = 1'b0;
        if (is_hit) begin
            cyc();
            check("hit_one_cycle", hit_o, 0);
            check("impact_to_cool", state_o, 4'b1000);
        end

        c = 0;
        while (ready_o == 1'b0 && budget < 8000) begin
            f = ($urandom % 100) < frame_pct;
            z = ($urandom % 100) < freeze_pct;
            frame_i  = f;
            freeze_i = z;
            fire_i   = noisy_fire && (($urandom % 4) == 0);
            fire_x_i = 10'($urandom % 1024);
            cyc();
            budget++;
            if (f && !z) c++;
            check("hit_in_cool", hit_o, 0);
            check("y_in_cool", laser_y_o, y0 + 8 * k);
            if (c < 9) check("state_cool", state_o, 4'b1000);
        end
        check("cool_frames", c, 9);
        check("idle_after_cool", state_o, 4'b0001);
        fire_i = 1'b0; frame_i = 1'b0; freeze_i = 1'b0;
    endtask

    initial begin
        int x0, y0, pl;

        // Reset
        reset_i = 1'b1;
        fire_i = 1'b1; fire_x_i = 10'd77; fire_y_i = 10'd55;
        cyc(); cyc();
        reset_i = 1'b0; fire_i = 1'b0;
        check("rst_state", state_o, 4'b0001);
        check("rst_ready", ready_o, 1);
        check("rst_hit", hit_o, 0);
        check("rst_active", active_o, 0);
        check("rst_x", laser_x_o, 0);
        check("rst_y", laser_y_o, 0);
        check("color", {laser_red_o, laser_green_o, laser_blue_o}, 12'hFFF);

        // Direct hit, miss beside the player, dead player
        run_shot(260, 100, 249, 289, 1'b1, 50, 0, 1'b0);
        run_shot(100, 100, 249, 289, 1'b1, 50, 0, 1'b0);
        run_shot(260, 440, 249, 289, 1'b0, 50, 0, 1'b0);

        // Freeze mid-flight, ignored fire, fire+reset priority
        player_left_i = 10'd249; player_right_i = 10'd289; player_alive_i = 1'b1;
        fire_i = 1'b1; fire_x_i = 10'd260; fire_y_i = 10'd192;
        cyc();
        fire_i = 1'b0; frame_i = 1'b1;
        cyc();
        frame_i = 1'b0;
        check("frz_pre_y", laser_y_o, 200);
        freeze_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame_i = 1'b1; cyc();
            frame_i = 1'b0; cyc();
        end
        check("frz_y", laser_y_o, 200);
        check("frz_state", state_o, 4'b0010);
        freeze_i = 1'b0; frame_i = 1'b1;
        cyc();
        frame_i = 1'b0;
        check("frz_release_y", laser_y_o, 208);
        fire_i = 1'b1; fire_x_i = 10'd500; fire_y_i = 10'd10;
        cyc();
        fire_i = 1'b0;
        check("ignored_fire_x", laser_x_o, 260);
        check("ignored_fire_y", laser_y_o, 208);
        reset_i = 1'b1; fire_i = 1'b1;
        cyc();
        reset_i = 1'b0; fire_i = 1'b0;
        check("rst_fire_state", state_o, 4'b0001);
        check("rst_fire_y", laser_y_o, 0);
        check("rst_fire_ready", ready_o, 1);

        // Randomized shots with freezes and stray fire requests
        for (int s = 0; s < 24; s++) begin
            pl = int'($urandom % 600);
            if (s % 2 == 0) x0 = pl - 2 + int'($urandom % 44);
            else x0 = int'($urandom % 637);
            if (x0 < 0) x0 = 0;
            if (x0 > 636) x0 = 636;
            y0 = int'($urandom % 471);
            run_shot(x0, y0, pl, pl + 40, ($urandom % 4) != 0, 40, 25, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
